bcd_seg_scanner: RTL and testbench
==================================

// Module: bcd_seg_scanner
// PURPOSE
//  Drives a 4-digit multiplexed 7-segment display from the 16-bit packed BCD word produced by the
//  binary-to-BCD converter stage (digit3 = bcd_in[15:12] ... digit0 = bcd_in[3:0]).
//  Contains refresh prescaler, digit scan counter, tear-free double buffering, leading-zero blanking
//  and segment decode. Sits between the BCD converter and the board display pins.
// PARAMETERS
//  REFRESH_DIV   50000  clk cycles each digit is lit (>=2); 50 MHz -> 1 kHz/digit
//  SEG_ACT_LOW   1      1: seg/dp lit when 0; 0: lit when 1
//  AN_ACT_LOW    1      1: anode enabled when 0; 0: enabled when 1
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst         in   1   synchronous, active-high reset
//  bcd_in      in   16  packed BCD value, 4 nibbles
//  bcd_valid   in   1   1-cycle strobe: capture bcd_in
//  blank_en    in   1   1: suppress leading zeros
//  dp_in       in   4   decimal point per digit, bit k = digit k
//  seg         out  7   {g,f,e,d,c,b,a}, registered
//  dp          out  1   decimal point of current digit, registered
//  an          out  4   digit enables, bit k = digit k, one-hot (or none), registered
//  frame_tick  out  1   1-cycle pulse on each digit3->digit0 wrap
// BEHAVIOUR
//  - Reset (rst=1 at edge): presc=0, idx=0, disp_reg=0, pend_reg=0, pend_flag=0; outputs all inactive:
//    an all off, seg all off, dp off, frame_tick=0. Applies mid-scan too; reset wins over every input.
//  - Prescaler: presc counts 0..REFRESH_DIV-1; tick=(presc==REFRESH_DIV-1); wraps to 0 on tick.
//  - Scan: idx (2b) advances on tick, order 0,1,2,3,0...; wrap=tick&&(idx==3); frame_tick<=wrap.
//  - Buffering: bcd_valid -> pend_reg<=bcd_in, pend_flag<=1 (later strobe overwrites earlier).
//    On wrap: if bcd_valid same cycle, disp_reg<=bcd_in, pend_flag<=0; else if pend_flag,
//    disp_reg<=pend_reg, pend_flag<=0. disp_reg changes only on wrap -> no torn frames.
//  - Blanking: digit k (k=3..1) blank when blank_en && disp_reg nibbles k..3 all zero.
//    Digit0 never blanked. Blanked digit: an bit inactive, seg off, dp off.
//  - Decode: 0-9 standard patterns; nibble 10-15 (invalid BCD) -> '-' (g only).
//  - Output regs load every cycle from current idx/disp_reg: seg/an/dp reflect new idx one cycle after
//    idx changes (latency 1). Never two anodes active. dp = dp_in[idx] sampled live.
//  - Polarity applied at output register per SEG_ACT_LOW / AN_ACT_LOW.
// STRUCTURE
//  - Package seg_pkg: 7-bit active-high digit patterns (0-9, DASH, OFF), segment bit order constants.
//  - Sub-module seg7_decode (combinational nibble -> active-high 7-bit pattern); top does polarity,
//    counters, buffering, blanking, output regs.
// TESTING  (REFRESH_DIV=4, active-low; patterns: 0=40 1=79 4=19 7=78 dash=3F off=7F)
//  1 rst held 3 cycles -> an=1111, seg=7F, dp=1, frame_tick=0; release -> digit0 lit after 1 cycle.
//  2 bcd_in=16'h1234 strobed, blank_en=0 -> after next frame_tick: an=1110 seg=19, then each digit 4
//    cycles: 1101/3, 1011/2, 0111/1 (seg=79); frame_tick every 16 cycles.
//  3 16'h0070, blank_en=1 -> digits3,2 an bits stay 1; digit1 seg=78; digit0 seg=40.
//    16'h0000, blank_en=1 -> only an=1110 seg=40 ever active.
//  4 16'hA005 -> digit3 seg=3F, digits2,1 seg=40 (blank_en=0), digit0 '5'.
//  5 strobe 16'h1111 mid-frame then 16'h2222 before wrap -> next frame shows 2222 only; strobe 16'h3333
//    exactly on wrap cycle -> that frame shows 3333; pend_flag cleared.
//  6 rst asserted while idx=2 -> next cycle all outputs inactive, idx=0, display value 0000.

Source files
------------

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - segment bit order and active-high 7-segment glyph constants
package seg_pkg;

  // Bit positions inside a {g,f,e,d,c,b,a} pattern
  localparam int SEG_BIT_A = 0;
  localparam int SEG_BIT_B = 1;
  localparam int SEG_BIT_C = 2;
  localparam int SEG_BIT_D = 3;
  localparam int SEG_BIT_E = 4;
  localparam int SEG_BIT_F = 5;
  localparam int SEG_BIT_G = 6;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'(1 << SEG_BIT_G);
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef logic [1:0] digit_idx_t;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - nibble to active-high 7-segment pattern, invalid BCD shown as dash
module seg7_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    case (nibble)
      4'd0: pattern = SEG_0;
      4'd1: pattern = SEG_1;
      4'd2: pattern = SEG_2;
      4'd3: pattern = SEG_3;
      4'd4: pattern = SEG_4;
      4'd5: pattern = SEG_5;
      4'd6: pattern = SEG_6;
      4'd7: pattern = SEG_7;
      4'd8: pattern = SEG_8;
      4'd9: pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// rtl/bcd_seg_scanner.sv - 4-digit multiplexed 7-segment scanner with double-buffered BCD input
module bcd_seg_scanner
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        bcd_valid,
  input  logic        blank_en,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_XOR = {7{SEG_ACT_LOW}};
  localparam logic [3:0] AN_XOR  = {4{AN_ACT_LOW}};

  logic [PW-1:0] presc;
  digit_idx_t    idx;
  logic [15:0]   disp_reg;
  logic [15:0]   pend_reg;
  logic          pend_flag;

  logic       tick;
  logic       wrap;
  logic [3:0] blank;
  logic [3:0] cur_nib;
  logic [6:0] cur_pat;
  logic [6:0] seg_lit;
  logic [3:0] an_lit;
  logic       dp_lit;

  assign tick = (presc == PRESC_MAX);
  assign wrap = tick && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) idx <= idx + 1'b1;
    end
  end

  // disp_reg only moves on wrap so a frame is never drawn from two different values
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_reg  <= '0;
      pend_reg  <= '0;
      pend_flag <= 1'b0;
    end else begin
      if (bcd_valid) begin
        pend_reg  <= bcd_in;
        pend_flag <= 1'b1;
      end
      if (wrap) begin
        if (bcd_valid) begin
          disp_reg  <= bcd_in;
          pend_flag <= 1'b0;
        end else if (pend_flag) begin
          disp_reg  <= pend_reg;
          pend_flag <= 1'b0;
        end
      end
    end
  end

  // A digit is a leading zero when it and every digit above it are zero
  always_comb begin
    blank    = 4'b0000;
    blank[3] = blank_en && (disp_reg[15:12] == 4'd0);
    blank[2] = blank[3] && (disp_reg[11:8] == 4'd0);
    blank[1] = blank[2] && (disp_reg[7:4] == 4'd0);
  end

  assign cur_nib = disp_reg[{idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .nibble  (cur_nib),
    .pattern (cur_pat)
  );

  always_comb begin
    seg_lit = blank[idx] ? SEG_OFF : cur_pat;
    an_lit  = blank[idx] ? 4'b0000 : (4'b0001 << idx);
    dp_lit  = dp_in[idx] && !blank[idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg        <= SEG_OFF ^ SEG_XOR;
      an         <= 4'b0000 ^ AN_XOR;
      dp         <= SEG_ACT_LOW;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_lit ^ SEG_XOR;
      an         <= an_lit ^ AN_XOR;
      dp         <= dp_lit ^ SEG_ACT_LOW;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// tb/tb_bcd_seg_scanner.sv - randomized self-checking bench for bcd_seg_scanner
module tb_bcd_seg_scanner;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = '0;
  logic        bcd_valid = 1'b0;
  logic        blank_en = 1'b0;
  logic [3:0]  dp_in = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  bcd_seg_scanner #(
    .REFRESH_DIV (DIV),
    .SEG_ACT_LOW (1'b1),
    .AN_ACT_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .bcd_valid  (bcd_valid),
    .blank_en   (blank_en),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference: edge count since reset, the shown value, and the newest value strobed since the last wrap
  int          m_edge = 0;
  logic [15:0] m_disp = '0;
  logic [15:0] m_latest = '0;
  logic        m_new = 1'b0;
  logic        cur_blank = 1'b0;
  logic [3:0]  cur_dp = 4'b0000;
  logic [6:0]  pat_tab [10];

  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_dp;
  logic       exp_ft;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [15:0] b);
    int          k;
    logic [15:0] upper;
    logic [3:0]  nib;
    logic [6:0]  pat;
    logic        blanked;
    @(negedge clk);
    rst = r; bcd_valid = v; bcd_in = b; blank_en = cur_blank; dp_in = cur_dp;
    if (r) begin
      exp_seg = 7'h7F; exp_an = 4'hF; exp_dp = 1'b1; exp_ft = 1'b0;
      m_edge = 0; m_disp = '0; m_new = 1'b0;
    end else begin
      k       = (m_edge / DIV) % 4;
      upper   = m_disp >> (4 * k);
      nib     = upper[3:0];
      blanked = (k != 0) && cur_blank && (upper == 16'd0);
      pat     = (nib <= 4'd9) ? pat_tab[nib] : 7'h40;
      exp_seg = blanked ? 7'h7F : ~pat;
      exp_an  = blanked ? 4'hF : ~(4'b0001 << k);
      exp_dp  = blanked ? 1'b1 : ~cur_dp[k];
      exp_ft  = ((m_edge % FRAME) == FRAME - 1);
      if (v) begin
        m_latest = b;
        m_new    = 1'b1;
      end
      if (exp_ft) begin
        if (m_new) m_disp = m_latest;
        m_new = 1'b0;
      end
      m_edge++;
    end
    @(posedge clk);
    #1;
    check("seg", 32'(seg), 32'(exp_seg));
    check("an", 32'(an), 32'(exp_an));
    check("dp", 32'(dp), 32'(exp_dp));
    check("frame_tick", 32'(frame_tick), 32'(exp_ft));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  // Steps until the edge just taken was a wrap edge
  task automatic run_to_wrap();
    do step(1'b0, 1'b0, 16'h0); while ((m_edge % FRAME) != 0);
  endtask

  task automatic show(input logic [15:0] value, input logic be);
    cur_blank = be;
    step(1'b0, 1'b1, value);
    run_to_wrap();
    idle(FRAME);
  endtask

  initial begin
    pat_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // reset held, then release
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h9999);
    check("rst_an", 32'(an), 32'h0000000F);
    check("rst_seg", 32'(seg), 32'h0000007F);
    step(1'b0, 1'b0, 16'h0);
    check("release_an", 32'(an), 32'h0000000E);
    check("release_seg", 32'(seg), 32'h00000040);

    // plain value, then first digit of the new frame
    cur_blank = 1'b0;
    step(1'b0, 1'b1, 16'h1234);
    run_to_wrap();
    step(1'b0, 1'b0, 16'h0);
    check("f1234_an", 32'(an), 32'h0000000E);
    check("f1234_seg", 32'(seg), 32'h00000019);
    idle(2 * FRAME);

    show(16'h0070, 1'b1);
    show(16'h0000, 1'b1);
    show(16'hA005, 1'b0);
    cur_dp = 4'b1010;
    show(16'h0305, 1'b1);
    cur_dp = 4'b0000;

    // two strobes in one frame: only the later one shows
    idle(5);
    step(1'b0, 1'b1, 16'h1111);
    idle(3);
    step(1'b0, 1'b1, 16'h2222);
    run_to_wrap();
    idle(FRAME);

    // strobe landing exactly on the wrap edge
    while ((m_edge % FRAME) != FRAME - 1) step(1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h3333);
    step(1'b0, 1'b0, 16'h0);
    check("wrap_strobe_seg", 32'(seg), 32'h00000030);
    idle(2 * FRAME);

    // reset in the middle of digit 2
    while (((m_edge / DIV) % 4) != 2) step(1'b0, 1'b0, 16'h0);
    step(1'b1, 1'b0, 16'h0);
    check("midrst_an", 32'(an), 32'h0000000F);
    check("midrst_dp", 32'(dp), 32'h00000001);
    cur_blank = 1'b0;
    step(1'b0, 1'b0, 16'h0);
    check("postrst_seg", 32'(seg), 32'h00000040);
    idle(FRAME);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      cur_blank = 1'($urandom_range(0, 1));
      cur_dp    = 4'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0), 16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
